// File: rtl/fpga_io_edge_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpga_io_edge_ctrl_if                                                     |
// | Config scan chain and pad/fabric bus for one IO tile row.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fpga_io_edge_ctrl_if #(
    parameter int NUM_IO = 10
);
    logic              scan_en;
    logic              scan_in;
    logic              scan_out;
    logic              cfg_commit;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_IO-1:0] pad_in;
    logic [NUM_IO-1:0] pad_out;
    logic [NUM_IO-1:0] pad_oe;
    logic [NUM_IO-1:0] fab_out;
    logic [NUM_IO-1:0] fab_in;

    modport master (
        output scan_en, scan_in, cfg_commit, pad_in, fab_out,
        input  scan_out, cfg_ready, cfg_err, pad_out, pad_oe, fab_in
    );

    modport slave (
        input  scan_en, scan_in, cfg_commit, pad_in, fab_out,
        output scan_out, cfg_ready, cfg_err, pad_out, pad_oe, fab_in
    );
endinterface
`default_nettype wire

// File: rtl/fpga_io_edge_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpga_io_edge_ctrl                                                        |
// | Scan-configured IO tile row with checked shadow-to-active commit.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fpga_io_edge_ctrl #(
    parameter int NUM_IO      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fpga_io_edge_ctrl_if.slave io
);
    localparam int CFG_BITS = 4;
    localparam int TOT      = NUM_IO * CFG_BITS;
    localparam int CNT_W    = $clog2(TOT + 1);
    localparam logic [CNT_W-1:0] TOT_CNT = CNT_W'(TOT);
    localparam int OE_BIT    = 0;
    localparam int OREG_BIT  = 1;
    localparam int IREG_BIT  = 2;
    localparam int ISYNC_BIT = 3;

    logic [TOT-1:0]   shadow_q,  shadow_d;
    logic [TOT-1:0]   active_q,  active_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic [NUM_IO-1:0]                  out_q;
    logic [NUM_IO-1:0]                  in_q;
    logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_q;

    logic              w_cfg_ready;
    logic              w_commit_ok;
    logic [NUM_IO-1:0] w_pad_oe;
    logic [NUM_IO-1:0] w_pad_out;
    logic [NUM_IO-1:0] w_fab_in;

    assign w_cfg_ready = (bit_cnt_q == TOT_CNT);
    assign w_commit_ok = io.cfg_commit && !io.scan_en && w_cfg_ready;

    // A commit can only be accepted with scan_en low, so shift and load never collide.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q;
        cfg_err_d = cfg_err_q;
        if (io.scan_en) begin
            shadow_d = {shadow_q[TOT-2:0], io.scan_in};
            if (bit_cnt_q != TOT_CNT) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        if (io.cfg_commit) begin
            if (w_commit_ok) begin
                active_d  = shadow_q;
                bit_cnt_d = '0;
                cfg_err_d = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            bit_cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Pad registers run every cycle regardless of mode, so a mode switch is glitch-free but unflushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            in_q   <= '0;
            sync_q <= '0;
        end else begin
            out_q  <= io.fab_out;
            in_q   <= io.pad_in;
            sync_q <= {sync_q[SYNC_STAGES-2:0], io.pad_in};
        end
    end

    generate
        for (genvar i = 0; i < NUM_IO; i++) begin : g_tile
            logic [CFG_BITS-1:0] w_cfg;
            assign w_cfg        = active_q[CFG_BITS*i +: CFG_BITS];
            assign w_pad_oe[i]  = w_cfg[OE_BIT];
            assign w_pad_out[i] = w_cfg[OREG_BIT] ? out_q[i] : io.fab_out[i];
            assign w_fab_in[i]  = w_cfg[ISYNC_BIT] ? sync_q[SYNC_STAGES-1][i] :
                                  (w_cfg[IREG_BIT] ? in_q[i] : io.pad_in[i]);
        end
    endgenerate

    assign io.pad_oe    = w_pad_oe;
    assign io.pad_out   = w_pad_out;
    assign io.fab_in    = w_fab_in;
    assign io.scan_out  = shadow_q[TOT-1];
    assign io.cfg_ready = w_cfg_ready;
    assign io.cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_io_edge_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fpga_io_edge_ctrl                                                     |
// | Randomized scoreboard bench against a queue-based reference model.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fpga_io_edge_ctrl;
    localparam int NUM_IO      = 10;
    localparam int SYNC_STAGES = 2;
    localparam int TOT         = NUM_IO * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpga_io_edge_ctrl_if #(.NUM_IO(NUM_IO)) bus ();

    fpga_io_edge_ctrl #(
        .NUM_IO      (NUM_IO),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        int                cyc;
        logic [NUM_IO-1:0] oe;
        logic [NUM_IO-1:0] pout;
        logic [NUM_IO-1:0] fin;
        logic              so;
        logic              rdy;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: shadow is the list of the last TOT bits shifted (oldest first),
    // pad history holds pad_in values from 1..SYNC_STAGES cycles ago.
    bit                sh_q[$];
    int                m_cnt;
    logic [TOT-1:0]    m_act;
    logic              m_err;
    logic [NUM_IO-1:0] pi_hist[$];
    logic [NUM_IO-1:0] fo_prev;

    function automatic void model_reset();
        sh_q = {};
        repeat (TOT) sh_q.push_back(1'b0);
        pi_hist = {};
        repeat (SYNC_STAGES) pi_hist.push_back('0);
        m_cnt   = 0;
        m_act   = '0;
        m_err   = 1'b0;
        fo_prev = '0;
    endfunction

    function automatic void model_edge();
        if (!rst_n) return;
        if (bus.cfg_commit) begin
            if (!bus.scan_en && m_cnt == TOT) begin
                for (int k = 0; k < TOT; k++) m_act[TOT-1-k] = sh_q[k];
                m_cnt = 0;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (bus.scan_en) begin
            sh_q.push_back(bus.scan_in);
            void'(sh_q.pop_front());
            if (m_cnt < TOT) m_cnt++;
        end
        pi_hist.push_front(bus.pad_in);
        void'(pi_hist.pop_back());
        fo_prev = bus.fab_out;
    endfunction

    function automatic exp_t model_expect();
        exp_t       e;
        logic [3:0] t;
        e.cyc = cyc;
        for (int i = 0; i < NUM_IO; i++) begin
            t          = m_act[4*i +: 4];
            e.oe[i]    = t[0];
            e.pout[i]  = t[1] ? fo_prev[i] : bus.fab_out[i];
            e.fin[i]   = t[3] ? pi_hist[SYNC_STAGES-1][i] :
                         (t[2] ? pi_hist[0][i] : bus.pad_in[i]);
        end
        e.so  = sh_q[0];
        e.rdy = (m_cnt == TOT);
        e.err = m_err;
        return e;
    endfunction

    // One clock cycle: model follows the edge, then new inputs are applied and the expectation queued.
    task automatic tick(input logic sen, input logic sin, input logic com, input logic rstv = 1'b1);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        rst_n          = rstv;
        bus.scan_en    = sen;
        bus.scan_in    = sin;
        bus.cfg_commit = com;
        bus.pad_in     = NUM_IO'($urandom);
        bus.fab_out    = NUM_IO'($urandom);
        if (!rstv) model_reset();
        exp_q.push_back(model_expect());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic shift_seq(input logic [TOT-1:0] w, input int pre, input int n, input bit gaps);
        for (int k = 0; k < pre; k++) tick(1'b1, 1'($urandom), 1'b0);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick(1'b0, 1'($urandom), 1'b0);
            tick(1'b1, w[TOT-1-k], 1'b0);
        end
    endtask

    task automatic commit();
        tick(1'b0, 1'b0, 1'b1);
        idle(5);
    endtask

    function automatic void chk(input string name, input int c,
                                input logic [NUM_IO-1:0] got, input logic [NUM_IO-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pad_oe",    e.cyc, bus.pad_oe,  e.oe);
            chk("pad_out",   e.cyc, bus.pad_out, e.pout);
            chk("fab_in",    e.cyc, bus.fab_in,  e.fin);
            chk("scan_out",  e.cyc, NUM_IO'(bus.scan_out),  NUM_IO'(e.so));
            chk("cfg_ready", e.cyc, NUM_IO'(bus.cfg_ready), NUM_IO'(e.rdy));
            chk("cfg_err",   e.cyc, NUM_IO'(bus.cfg_err),   NUM_IO'(e.err));
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [TOT-1:0] w;
        bus.scan_en    = 1'b0;
        bus.scan_in    = 1'b0;
        bus.cfg_commit = 1'b0;
        bus.pad_in     = '0;
        bus.fab_out    = '0;
        model_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Full load: tile0 OE+OREG.
        w = TOT'(4'b0011);
        shift_seq(w, 0, TOT, 1'b0);
        commit();

        // Short load rejected, completed load accepted.
        w = TOT'(4'b0001) << 8;
        shift_seq(w, 0, TOT - 1, 1'b0);
        commit();
        tick(1'b1, w[0], 1'b0);
        commit();

        // Commit while shifting with ready already high.
        w = '1;
        shift_seq(w, 0, TOT, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        idle(4);

        // Tile 3 input modes.
        w = TOT'(4'b1000) << 12; shift_seq(w, 0, TOT, 1'b0); commit();
        w = TOT'(4'b1100) << 12; shift_seq(w, 0, TOT, 1'b0); commit();
        w = TOT'(4'b0100) << 12; shift_seq(w, 0, TOT, 1'b0); commit();
        w = '0;                  shift_seq(w, 0, TOT, 1'b0); commit();

        // Overshift by 5 bits.
        w = {$urandom, $urandom};
        shift_seq(w, 5, TOT, 1'b0);
        idle(2);
        commit();

        // Reset mid-shift, then commit must be rejected.
        w = {$urandom, $urandom};
        shift_seq(w, 0, 20, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        commit();

        for (int r = 0; r < 25; r++) begin
            w = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       shift_seq(w, 0, TOT - $urandom_range(1, 3), 1'b1);
                1:       shift_seq(w, $urandom_range(1, 5), TOT, 1'b1);
                default: shift_seq(w, 0, TOT, 1'b1);
            endcase
            if ($urandom_range(0, 4) == 0) begin
                tick(1'b1, 1'($urandom), 1'b1);
                idle(3);
            end else begin
                commit();
            end
            if (r % 10 == 7) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0);
                idle(3);
            end
        end

        idle(3);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
